// File: rtl/loop_pkg.sv
// loop_pkg: shared types and constants for the looper SRAM back end
package loop_pkg;
  localparam int DATA_W = 16;
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RECORD, PLAY} loop_state_e;
  typedef enum logic [1:0] {A_IDLE, A_PH1, A_PH2, A_OUT} acc_state_e;
endpackage

// File: rtl/loop_sram_ctrl_if.sv
// loop_sram_ctrl_if: live sample stream in and mixed sample stream out
interface loop_sram_ctrl_if;
  import loop_pkg::*;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  modport master (output i_valid, i_data, input o_valid, o_data);
  modport slave  (input i_valid, i_data, output o_valid, o_data);
endinterface

// File: rtl/sat_add.sv
// sat_add: signed saturating adder, result clamped to the sample range
module sat_add
  import loop_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);
  logic [DATA_W:0] sum;
  assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign y = sum[DATA_W] != sum[DATA_W-1] ? (sum[DATA_W] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];
endmodule

// File: rtl/loop_sram_ctrl.sv
// loop_sram_ctrl: looper back end recording samples to async SRAM and mixing the stored loop on playback
module loop_sram_ctrl
  import loop_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int MAX_LEN = 2**ADDR_W - 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd,
  input  logic              i_clear,
  loop_sram_ctrl_if.slave   strm,
  output logic [1:0]        o_state,
  output logic [ADDR_W-1:0] o_len,
  output logic              o_overrun,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  loop_state_e loop_q, loop_d, mode_q, mode_d;
  acc_state_e acc_q, acc_d;
  logic [ADDR_W-1:0] wr_q, wr_d, rd_q, rd_d, len_q, len_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, loop_r_q, loop_r_d, mix;
  logic ovr_q, ovr_d, pend_q, pend_d;
  logic acc_idle, take, cmd_now, mem_ph;
  assign acc_idle = acc_q == A_IDLE;
  assign take = strm.i_valid && acc_idle;
  assign cmd_now = i_cmd || pend_q;
  assign mem_ph = acc_q == A_PH1 || acc_q == A_PH2;
  sat_add u_sat (.a(data_q), .b(loop_r_q), .y(mix));
  always_comb begin
    loop_d = loop_q;
    mode_d = mode_q;
    wr_d = wr_q;
    rd_d = rd_q;
    len_d = len_q;
    addr_d = addr_q;
    data_d = data_q;
    loop_r_d = loop_r_q;
    ovr_d = ovr_q || (strm.i_valid && !acc_idle);
    pend_d = cmd_now;
    acc_d = acc_idle ? (take ? A_PH1 : A_IDLE) : acc_q == A_PH1 ? A_PH2 : acc_q == A_PH2 ? A_OUT : A_IDLE;
    if (take) begin
      data_d = strm.i_data;
      mode_d = loop_q;
      addr_d = loop_q == PLAY ? rd_q : wr_q;
    end
    if (acc_q == A_PH2 && mode_q == PLAY) begin
      loop_r_d = io_SRAM_DQ;
      rd_d = rd_q == len_q - ONE ? '0 : rd_q + ONE;
    end
    // a full SRAM ends the take and starts playback on its own
    if (acc_q == A_PH2 && mode_q == RECORD) begin
      wr_d = wr_q + ONE;
      if (wr_q + ONE == MAX_A && loop_q == RECORD) begin
        loop_d = PLAY;
        len_d = MAX_A;
        rd_d = '0;
      end
    end
    // commands only land in a quiet cycle so an access never sees its mode change
    if (acc_idle && !strm.i_valid && cmd_now) begin
      pend_d = 1'b0;
      if (loop_q == IDLE) begin
        loop_d = RECORD;
        wr_d = '0;
        len_d = '0;
      end else if (loop_q == RECORD) begin
        loop_d = wr_q == '0 ? IDLE : PLAY;
        len_d = wr_q;
        rd_d = '0;
      end else begin
        loop_d = IDLE;
      end
    end
    if (i_clear) begin
      loop_d = IDLE;
      len_d = '0;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      loop_q <= IDLE;
      mode_q <= IDLE;
      acc_q <= A_IDLE;
      wr_q <= '0;
      rd_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      loop_r_q <= '0;
      ovr_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      loop_q <= loop_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      len_q <= len_d;
      addr_q <= addr_d;
      data_q <= data_d;
      loop_r_q <= loop_r_d;
      ovr_q <= ovr_d;
      pend_q <= pend_d;
    end
  end
  assign o_state = loop_q;
  assign o_len = len_q;
  assign o_overrun = ovr_q;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = !(mem_ph && mode_q != IDLE);
  assign o_SRAM_LB_N = o_SRAM_CE_N;
  assign o_SRAM_UB_N = o_SRAM_CE_N;
  assign o_SRAM_WE_N = !(acc_q == A_PH1 && mode_q == RECORD);
  assign o_SRAM_OE_N = !(mem_ph && mode_q == PLAY);
  assign io_SRAM_DQ = (mem_ph && mode_q == RECORD) ? data_q : 'z;
  assign strm.o_valid = acc_q == A_OUT;
  assign strm.o_data = mode_q == PLAY ? mix : data_q;
endmodule
